// File: rtl/bitcount_pkg.sv
// rtl/bitcount_pkg.sv - shared widths and FSM state type for the bit-count sequencer
package bitcount_pkg;

  localparam int W     = 8;
  localparam int RES_W = 4;
  localparam int TOT_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_WAIT_DONE,
    ST_RELEASE
  } state_t;

endpackage

// File: rtl/op_fifo.sv
// rtl/op_fifo.sv - operand FIFO with registered full/empty and show-ahead head output
module op_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push_ok;
  logic          w_pop_ok;
  logic [AW:0]   w_count_nxt;

  assign w_push_ok = push & ~full;
  assign w_pop_ok  = pop & ~empty;
  assign dout      = r_mem[r_rd_ptr];

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + (AW+1)'(1);
      2'b01:   w_count_nxt = r_count - (AW+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Flags come from the next occupancy so they are registered yet never stale.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      full    <= (w_count_nxt == FULL_CNT);
      empty   <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/bitcount_sequencer.sv
// rtl/bitcount_sequencer.sv - feeds queued operands to an external bit counter and accumulates counts
module bitcount_sequencer
  import bitcount_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = bitcount_pkg::W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     data_in,
  output logic             full,
  output logic             empty,
  output logic [W-1:0]     A,
  output logic             s,
  input  logic             done,
  input  logic [RES_W-1:0] result,
  output logic             res_valid,
  output logic [RES_W-1:0] res_data,
  output logic [TOT_W-1:0] total
);

  state_t       r_state;
  logic         w_pop;
  logic [W-1:0] w_head;
  logic [TOT_W:0] w_sum;

  assign w_pop = (r_state == ST_WAIT_DONE) && done;
  assign w_sum = {1'b0, total} + {{(TOT_W+1-RES_W){1'b0}}, result};

  op_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (w_pop),
    .din   (data_in),
    .dout  (w_head),
    .full  (full),
    .empty (empty)
  );

  // The operand stays at the FIFO head until capture, so A is latched once on entry to LOAD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      s         <= 1'b0;
      A         <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      total     <= '0;
    end else begin
      res_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          s <= 1'b0;
          if (!empty) begin
            A       <= w_head;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          s       <= 1'b1;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          r_state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (done) begin
            res_data  <= result;
            total     <= w_sum[TOT_W] ? '1 : w_sum[TOT_W-1:0];
            res_valid <= 1'b1;
            s         <= 1'b0;
            r_state   <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          s <= 1'b0;
          if (!done) r_state <= ST_IDLE;
        end
        default: begin
          s       <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
